mem_port_arbiter: RTL and testbench

Shares one single-port data/instruction memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store). It sits between the two stages and the memory and runs a small request/acknowledge state machine. It returns read data to the owning stage and generates the global `stall` that holds the PC and every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) until the cycle's memory accesses complete. A watchdog aborts accesses the memory never acknowledges.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/arb_watchdog.sv | 33 +++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } arb_state_t;

  // Read data returned on a watchdog abort; sliced to DATA_W by the user.
  localparam logic [63:0] ERR_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/arb_watchdog.sv
// Cycle counter that flags an access the memory has not acknowledged in time.
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count un-acked busy cycles; saturate at the last value before abort.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= {CNT_W{1'b0}};
    end else if (clear) begin
      count <= {CNT_W{1'b0}};
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  // The edge that would take the count to TIMEOUT is the abort edge.
  assign expired = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// data port first, and raises the global pipeline stall.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              err
);

  localparam logic [DATA_W-1:0] ERR_WORD = ERR_RDATA[DATA_W-1:0];

  arb_state_t state;
  arb_state_t state_next;
  logic       busy;
  logic       expired;
  logic       d_pend;
  logic       i_pend;
  logic       issue_d;
  logic       issue_i;
  logic       finish;
  logic       abort;

  // A requester still holding req during its own valid cycle is already served.
  assign d_pend = d_req & ~d_valid;
  assign i_pend = i_req & ~i_valid;
  assign busy   = (state == D_BUSY) || (state == I_BUSY);
  assign stall  = (i_req & ~i_valid) | (d_req & ~d_valid);

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (~busy),
    .enable (busy & ~mem_ack),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration and completion decode.
  always_comb begin
    state_next = state;
    issue_d    = 1'b0;
    issue_i    = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (d_pend) begin
          issue_d    = 1'b1;
          state_next = D_BUSY;
        end else if (i_pend) begin
          issue_i    = 1'b1;
          state_next = I_BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      D_BUSY, I_BUSY: begin
        if (mem_ack) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if (expired) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = state;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory-side request registers and per-port return data/valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      i_rdata   <= {DATA_W{1'b0}};
      i_valid   <= 1'b0;
      d_rdata   <= {DATA_W{1'b0}};
      d_valid   <= 1'b0;
      err       <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      if (issue_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (issue_i) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= i_addr;
      end else if (finish || abort) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (finish || abort) begin
        if (state == D_BUSY) begin
          d_valid <= 1'b1;
          if (abort) begin
            d_rdata <= ERR_WORD;
          end else if (!mem_we) begin
            d_rdata <= mem_rdata;
          end
        end else begin
          i_valid <= 1'b1;
          i_rdata <= abort ? ERR_WORD : mem_rdata;
        end
      end
      if (abort) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand-written timeout and reset-mid-access sequences.
module tb_mem_port_arbiter;

  localparam logic [31:0] IA   = 32'h0040_0000;
  localparam logic [31:0] IA4  = 32'h0040_0004;
  localparam logic [31:0] IA8  = 32'h0040_0008;
  localparam logic [31:0] INS  = 32'h8C08_0004;
  localparam logic [31:0] INS2 = 32'h2402_0001;
  localparam logic [31:0] DA   = 32'h1001_0000;
  localparam logic [31:0] DW   = 32'hDEAD_BEEF;
  localparam logic [31:0] LA   = 32'h1001_0004;
  localparam logic [31:0] LW   = 32'hCAFE_F00D;
  localparam logic [31:0] LD   = 32'h1234_5678;
  localparam logic [31:0] G    = 32'hA5A5_A5A5;
  localparam logic [31:0] Z    = 32'h0000_0000;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        stall;
    logic        err;
  } obs_t;

  typedef struct {
    string       name;
    logic        chk;
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        ack;
    logic [31:0] mrdata;
    obs_t        exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        err;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];
  obs_t got;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_valid  (i_valid),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall    (stall),
    .err      (err)
  );

  assign got = {mem_req, mem_we, mem_addr, mem_wdata, i_valid, i_rdata,
                d_valid, d_rdata, stall, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input string name, input logic chk, input logic rst,
                             input logic ireq, input logic [31:0] iaddr,
                             input logic dreq, input logic dwe,
                             input logic [31:0] daddr, input logic [31:0] dwdata,
                             input logic ack, input logic [31:0] mrdata,
                             input logic e_req, input logic e_we,
                             input logic [31:0] e_addr, input logic [31:0] e_wdata,
                             input logic e_iv, input logic [31:0] e_ir,
                             input logic e_dv, input logic [31:0] e_dr,
                             input logic e_st, input logic e_err);
    vec_t r;
    r.name = name; r.chk = chk; r.rst = rst;
    r.ireq = ireq; r.iaddr = iaddr;
    r.dreq = dreq; r.dwe = dwe; r.daddr = daddr; r.dwdata = dwdata;
    r.ack = ack; r.mrdata = mrdata;
    r.exp = {e_req, e_we, e_addr, e_wdata, e_iv, e_ir, e_dv, e_dr, e_st, e_err};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
    tests++;
    if (actual !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, actual, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int n_busy;
    bit seen;
    bit err_early;

    reset = 1'b0; i_req = 1'b0; i_addr = Z; d_req = 1'b0; d_we = 1'b0;
    d_addr = Z; d_wdata = Z; mem_ack = 1'b0; mem_rdata = Z;

    //            name     chk  rst  ireq iaddr dreq dwe daddr dwdata ack mrdata | req we addr wdata iv ir dv dr stall err
    vecs.push_back(v("rst0",  1'b0, 1'b0, 1'b1, G,   1'b1, 1'b1, G,  G,  1'b1, G,    1'b0, 1'b0, Z,   Z,  1'b0, Z,    1'b0, Z,  1'b1, 1'b0));
    vecs.push_back(v("rst1",  1'b1, 1'b0, 1'b1, G,   1'b1, 1'b1, G,  G,  1'b1, G,    1'b0, 1'b0, Z,   Z,  1'b0, Z,    1'b0, Z,  1'b1, 1'b0));
    vecs.push_back(v("rst2",  1'b1, 1'b0, 1'b0, G,   1'b0, 1'b1, G,  G,  1'b1, G,    1'b0, 1'b0, Z,   Z,  1'b0, Z,    1'b0, Z,  1'b0, 1'b0));
    vecs.push_back(v("rst3",  1'b1, 1'b0, 1'b1, G,   1'b0, 1'b0, G,  G,  1'b0, G,    1'b0, 1'b0, Z,   Z,  1'b0, Z,    1'b0, Z,  1'b1, 1'b0));
    // Single fetch, ack on the third cycle of mem_req
    vecs.push_back(v("f0",    1'b1, 1'b1, 1'b1, IA,  1'b0, 1'b0, Z,  Z,  1'b0, Z,    1'b0, 1'b0, Z,   Z,  1'b0, Z,    1'b0, Z,  1'b1, 1'b0));
    vecs.push_back(v("f1",    1'b1, 1'b1, 1'b1, IA,  1'b0, 1'b0, Z,  Z,  1'b0, Z,    1'b1, 1'b0, IA,  Z,  1'b0, Z,    1'b0, Z,  1'b1, 1'b0));
    vecs.push_back(v("f2",    1'b1, 1'b1, 1'b1, IA,  1'b0, 1'b0, Z,  Z,  1'b0, Z,    1'b1, 1'b0, IA,  Z,  1'b0, Z,    1'b0, Z,  1'b1, 1'b0));
    vecs.push_back(v("f3",    1'b1, 1'b1, 1'b1, IA,  1'b0, 1'b0, Z,  Z,  1'b1, INS,  1'b1, 1'b0, IA,  Z,  1'b0, Z,    1'b0, Z,  1'b1, 1'b0));
    vecs.push_back(v("f4",    1'b1, 1'b1, 1'b1, IA,  1'b0, 1'b0, Z,  Z,  1'b0, Z,    1'b0, 1'b0, IA,  Z,  1'b1, INS,  1'b0, Z,  1'b0, 1'b0));
    vecs.push_back(v("f5",    1'b1, 1'b1, 1'b0, IA,  1'b0, 1'b0, Z,  Z,  1'b1, G,    1'b0, 1'b0, IA,  Z,  1'b0, INS,  1'b0, Z,  1'b0, 1'b0));
    vecs.push_back(v("f6",    1'b1, 1'b1, 1'b0, IA,  1'b0, 1'b0, Z,  Z,  1'b0, Z,    1'b0, 1'b0, IA,  Z,  1'b0, INS,  1'b0, Z,  1'b0, 1'b0));
    // Store and fetch together: store first, one idle cycle, then fetch
    vecs.push_back(v("s0",    1'b1, 1'b1, 1'b1, IA4, 1'b1, 1'b1, DA, DW, 1'b0, Z,    1'b0, 1'b0, IA,  Z,  1'b0, INS,  1'b0, Z,  1'b1, 1'b0));
    vecs.push_back(v("s1",    1'b1, 1'b1, 1'b1, IA4, 1'b1, 1'b1, DA, DW, 1'b1, 32'h5555_5555, 1'b1, 1'b1, DA, DW, 1'b0, INS, 1'b0, Z, 1'b1, 1'b0));
    vecs.push_back(v("s2",    1'b1, 1'b1, 1'b1, IA4, 1'b1, 1'b1, DA, DW, 1'b0, Z,    1'b0, 1'b0, DA,  DW, 1'b0, INS,  1'b1, Z,  1'b1, 1'b0));
    vecs.push_back(v("s3",    1'b1, 1'b1, 1'b1, IA4, 1'b0, 1'b0, Z,  Z,  1'b0, Z,    1'b1, 1'b0, IA4, DW, 1'b0, INS,  1'b0, Z,  1'b1, 1'b0));
    vecs.push_back(v("s4",    1'b1, 1'b1, 1'b1, IA4, 1'b0, 1'b0, Z,  Z,  1'b1, INS2, 1'b1, 1'b0, IA4, DW, 1'b0, INS,  1'b0, Z,  1'b1, 1'b0));
    vecs.push_back(v("s5",    1'b1, 1'b1, 1'b1, IA4, 1'b0, 1'b0, Z,  Z,  1'b0, Z,    1'b0, 1'b0, IA4, DW, 1'b1, INS2, 1'b0, Z,  1'b0, 1'b0));
    vecs.push_back(v("s6",    1'b1, 1'b1, 1'b0, IA4, 1'b0, 1'b0, Z,  Z,  1'b0, Z,    1'b0, 1'b0, IA4, DW, 1'b0, INS2, 1'b0, Z,  1'b0, 1'b0));
    // Load with ack in the first busy cycle
    vecs.push_back(v("l0",    1'b1, 1'b1, 1'b0, Z,   1'b1, 1'b0, LA, LW, 1'b0, Z,    1'b0, 1'b0, IA4, DW, 1'b0, INS2, 1'b0, Z,  1'b1, 1'b0));
    vecs.push_back(v("l1",    1'b1, 1'b1, 1'b0, Z,   1'b1, 1'b0, LA, LW, 1'b1, LD,   1'b1, 1'b0, LA,  LW, 1'b0, INS2, 1'b0, Z,  1'b1, 1'b0));
    vecs.push_back(v("l2",    1'b1, 1'b1, 1'b0, Z,   1'b1, 1'b0, LA, LW, 1'b0, Z,    1'b0, 1'b0, LA,  LW, 1'b0, INS2, 1'b1, LD, 1'b0, 1'b0));
    vecs.push_back(v("l3",    1'b1, 1'b1, 1'b0, Z,   1'b0, 1'b0, Z,  Z,  1'b0, Z,    1'b0, 1'b0, LA,  LW, 1'b0, INS2, 1'b0, LD, 1'b0, 1'b0));

    next_cycle();
    foreach (vecs[k]) begin
      reset = vecs[k].rst; i_req = vecs[k].ireq; i_addr = vecs[k].iaddr;
      d_req = vecs[k].dreq; d_we = vecs[k].dwe; d_addr = vecs[k].daddr;
      d_wdata = vecs[k].dwdata; mem_ack = vecs[k].ack; mem_rdata = vecs[k].mrdata;
      @(negedge clk);
      if (vecs[k].chk) begin
        tests++;
        if (got !== vecs[k].exp) begin
          fails++;
          $display("FAIL vec %s: got req=%b we=%b addr=%h wd=%h iv=%b ir=%h dv=%b dr=%h stall=%b err=%b; expected req=%b we=%b addr=%h wd=%h iv=%b ir=%h dv=%b dr=%h stall=%b err=%b",
                   vecs[k].name, got.mem_req, got.mem_we, got.mem_addr, got.mem_wdata,
                   got.i_valid, got.i_rdata, got.d_valid, got.d_rdata, got.stall, got.err,
                   vecs[k].exp.mem_req, vecs[k].exp.mem_we, vecs[k].exp.mem_addr,
                   vecs[k].exp.mem_wdata, vecs[k].exp.i_valid, vecs[k].exp.i_rdata,
                   vecs[k].exp.d_valid, vecs[k].exp.d_rdata, vecs[k].exp.stall, vecs[k].exp.err);
        end
      end
      next_cycle();
    end

    // Timeout: fetch never acknowledged, abort after four busy cycles
    i_req = 1'b1; i_addr = IA8; d_req = 1'b0; mem_ack = 1'b0; mem_rdata = Z;
    seen = 1'b0; n_busy = 0; err_early = 1'b0; c = 0;
    while (!seen && c < 12) begin
      @(negedge clk);
      if (i_valid) begin
        seen = 1'b1;
      end else begin
        if (mem_req) n_busy++;
        if (err) err_early = 1'b1;
        next_cycle();
        c++;
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL to_valid: no i_valid within 12 cycles");
    end else begin
      check("to_latency", 32'(c), 32'd5);
      check("to_busy_cycles", 32'(n_busy), 32'd4);
      check("to_err_early", {31'd0, err_early}, 32'd0);
      check("to_err", {31'd0, err}, 32'd1);
      check("to_rdata", i_rdata, 32'hFFFF_FFFF);
      check("to_mem_req", {31'd0, mem_req}, 32'd0);
      check("to_d_rdata", d_rdata, LD);
    end
    next_cycle();
    i_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("to_err_sticky", {31'd0, err}, 32'd1);
      check("to_no_repulse", {31'd0, i_valid}, 32'd0);
      next_cycle();
    end

    // Reset while a store is outstanding: access abandoned, no d_valid
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0008; d_wdata = 32'h0BAD_F00D;
    next_cycle();
    @(negedge clk);
    check("rm_busy", {31'd0, mem_req}, 32'd1);
    check("rm_addr", mem_addr, 32'h1001_0008);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check("rm_mem_req", {31'd0, mem_req}, 32'd0);
    check("rm_d_valid", {31'd0, d_valid}, 32'd0);
    check("rm_err_cleared", {31'd0, err}, 32'd0);
    check("rm_mem_addr", mem_addr, Z);
    check("rm_d_rdata", d_rdata, Z);
    next_cycle();
    mem_ack = 1'b1; mem_rdata = G;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("rm_idle_req", {31'd0, mem_req}, 32'd0);
      check("rm_idle_dv", {31'd0, d_valid}, 32'd0);
      next_cycle();
      mem_ack = 1'b0;
    end

    // Fresh load right after reset proves the FSM is back in IDLE
    d_req = 1'b1; d_we = 1'b0; d_addr = LA; d_wdata = Z;
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'h0F0F_0F0F;
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    check("rm_load_dv", {31'd0, d_valid}, 32'd1);
    check("rm_load_data", d_rdata, 32'h0F0F_0F0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
